alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one alu_64bit instance between NREQ requesters (e.g. integer pipe and address/branch unit), using round-robin arbitration.
- Each requester uses a valid/ready request channel (a, b, alu_ctrl, tag) and a valid/ready response channel (result, zero, tag, err).
- Sequenced by a 3-state FSM. One operation is in flight at a time; operands and results are registered.

Parameters:
- NREQ, 2, number of requesters (2..4)
- XLEN, 64, operand/result width
- TAGW, 4, width of the opaque tag echoed back with the response

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accepted this cycle
- req_a  in  NREQ*XLEN  operand A, packed; requester i at [i*XLEN +: XLEN]
- req_b  in  NREQ*XLEN  operand B, packed the same way
- req_ctrl  in  NREQ*4  alu_ctrl code, packed
- req_tag  in  NREQ*TAGW  tag, packed
- rsp_valid  out  NREQ  response valid; one-hot or zero
- rsp_ready  in  NREQ  requester consumes the response
- rsp_result  out  XLEN  registered ALU result (shared bus)
- rsp_zero  out  1  registered ALU zero flag
- rsp_tag  out  TAGW  echoed tag
- rsp_err  out  1  alu_ctrl code was unsupported
- busy  out  1  high when the FSM is not IDLE

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high on rst.
- Values after reset:
  - state=IDLE, rr_ptr=0
  - rsp_valid=0, req_ready=0, busy=0
  - rsp_result=0, rsp_zero=0, rsp_tag=0, rsp_err=0
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant the first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready is combinational: it is 1 only for the granted index, and only in IDLE.
  - On handshake (valid & ready), latch a, b, ctrl, tag and owner index. Set rr_ptr = owner+1 mod NREQ. Go to EXEC.
  - If no request is valid: stay in IDLE; rr_ptr is unchanged.
- EXEC:
  - The latched operands drive alu_64bit.
  - At the clock edge, capture result, zero and err into the rsp_* registers. Go to RESP.
- RESP:
  - rsp_valid[owner]=1; all other bits are 0.
  - rsp_* outputs stay stable until rsp_ready[owner]=1, then go to IDLE.
  - rsp_ready on non-owner bits is ignored.
- Latency: request accepted at the edge ending cycle N; rsp_valid=1 in cycle N+2. Best-case throughput is one operation every 3 cycles.
- Supported alu_ctrl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0101, SRA 0111.
  - Any other code: rsp_err=1, rsp_result=0, rsp_zero=1, and the ALU output is ignored.
- Width and arithmetic: ADD/SUB wrap modulo 2^64. Shift amount is b[5:0]. rsp_zero = (result==0).
- A requester must hold its request fields stable while req_valid=1 and not yet accepted. The block does not check this.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by rr_ptr. Losers keep req_ready=0 and retry.
- No starvation: a continuously valid requester is granted within NREQ operations.
- Reset mid-operation: the in-flight operation is dropped, no response is issued, and all outputs return to their reset values on the next cycle.
- The response is held indefinitely if rsp_ready stays 0. busy stays 1 for that whole time.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_e with ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA
  - typedef enum arb_state_e {IDLE, EXEC, RESP}
  - function is_legal_op(logic [3:0]) returning bit
- Sub-module rr_arbiter (NREQ): combinational round-robin grant from req vector and rr_ptr; outputs one-hot grant plus index.
- alu_64bit is instantiated unchanged inside alu_share_arbiter.

Test Plan:
- Single ADD: req0 a=0x10, b=0x3, ctrl=0000, tag=5. Expect req_ready[0]=1 in cycle 0, then rsp_valid[0]=1 in cycle 2 with result=0x13, zero=0, tag=5, err=0.
- SUB to zero: req1 a=b=5, ctrl=0001. Expect rsp_valid[1]=1, result=0, zero=1.
- Contention: both requesters valid continuously after reset (req0 AND F0F0..F0 & 0F0F..0F, req1 OR AAAA..AA | 5555..55). Expect grant order 0,1,0,1; results 0 (zero=1) and FFFF_FFFF_FFFF_FFFF alternate.
- Backpressure: SRA a=0x8000_0000_0000_0000, b=1, with rsp_ready held 0 for 10 cycles. Expect result C000_0000_0000_0000 stable, busy=1, req_ready=0 throughout; IDLE returns one cycle after rsp_ready=1.
- Illegal op: ctrl=1111, a=1, b=1. Expect err=1, result=0, zero=1. Follow-up SLL a=1, b=2 gives result=4, err=0.
- Reset mid-op: assert rst in EXEC. Expect no rsp_valid, rr_ptr=0, busy=0 next cycle. A new req1 is then granted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing arbiter: ALU opcodes, arbiter FSM states
// and the legality check used to flag unsupported opcodes.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_SLL = 4'b0101,
        ALU_SRA = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // True only for opcodes the ALU implements; anything else is reported as an error.
    function automatic bit is_legal_op(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA: is_legal_op = 1'b1;
            default:                                             is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_64bit.sv
// Purely combinational 64-bit ALU. Unsupported opcodes produce zero.
module alu_64bit
    import alu_pkg::*;
(
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic [3:0]  i_alu_ctrl,
    output logic [63:0] o_result,
    output logic        o_zero
);

    // Opcode decode; shifts use only the low six bits of B.
    always_comb begin
        o_result = '0;
        case (i_alu_ctrl)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLL: o_result = i_a << i_b[5:0];
            ALU_SRA: o_result = 64'($signed(i_a) >>> i_b[5:0]);
            default: o_result = '0;
        endcase
        o_zero = (o_result == 64'd0);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after i_ptr,
// wrapping modulo NREQ. Produces a one-hot grant, its index and an any flag.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PTRW-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PTRW-1:0] o_idx,
    output logic            o_any
);

    // Walk the requests starting from the pointer; the first hit wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!o_any && i_req[PTRW'(j)]) begin
                o_any            = 1'b1;
                o_gnt[PTRW'(j)]  = 1'b1;
                o_idx            = PTRW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_64bit between NREQ requesters. One operation is in flight
// at a time: IDLE grants and latches operands, EXEC registers the ALU output,
// RESP holds the response until the owner takes it.
//
// Handshake: a transfer happens on a channel in any cycle where both valid
// and ready are high at the rising edge. Requesters hold request fields
// stable while valid is high and not yet accepted; the response bus is held
// stable while rsp_valid is high and the owner's rsp_ready is low.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 64,
    parameter int TAGW = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ*XLEN-1:0]              req_a,
    input  logic [NREQ*XLEN-1:0]              req_b,
    input  logic [NREQ*4-1:0]                 req_ctrl,
    input  logic [NREQ*TAGW-1:0]              req_tag,
    output logic [NREQ-1:0]                   rsp_valid,
    input  logic [NREQ-1:0]                   rsp_ready,
    output logic [XLEN-1:0]                   rsp_result,
    output logic                              rsp_zero,
    output logic [TAGW-1:0]                   rsp_tag,
    output logic                              rsp_err,
    output logic                              busy,
    output arb_state_e                        dbg_state,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] dbg_rr_ptr
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [PTRW-1:0]   r_rr_ptr;
    logic [PTRW-1:0]   r_owner;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [3:0]        r_ctrl;
    logic [TAGW-1:0]   r_tag;
    logic [XLEN-1:0]   r_rsp_result;
    logic              r_rsp_zero;
    logic [TAGW-1:0]   r_rsp_tag;
    logic              r_rsp_err;

    logic [NREQ-1:0]   w_gnt;
    logic [PTRW-1:0]   w_gnt_idx;
    logic              w_any;
    logic [63:0]       w_alu_result;
    logic              w_alu_zero;
    logic              w_legal;

    logic [XLEN-1:0]   w_a   [NREQ];
    logic [XLEN-1:0]   w_b   [NREQ];
    logic [3:0]        w_ctrl[NREQ];
    logic [TAGW-1:0]   w_tag [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g]    = req_a[g*XLEN +: XLEN];
        assign w_b[g]    = req_b[g*XLEN +: XLEN];
        assign w_ctrl[g] = req_ctrl[g*4 +: 4];
        assign w_tag[g]  = req_tag[g*TAGW +: TAGW];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_rr_arbiter (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    alu_64bit u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_alu_ctrl (r_ctrl),
        .o_result   (w_alu_result),
        .o_zero     (w_alu_zero)
    );

    assign w_legal = is_legal_op(r_ctrl);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant in IDLE, one cycle of EXEC, hold RESP until the owner is ready.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (rsp_ready[r_owner]) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: ready only for the grant in IDLE, response valid only for the owner in RESP.
    always_comb begin
        req_ready = (r_state == IDLE) ? w_gnt : '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (r_state == RESP) && (r_owner == PTRW'(i));
        end
        busy = (r_state != IDLE);
    end

    // Datapath: latch the granted request, then capture the ALU result into the response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_ctrl       <= '0;
            r_tag        <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_gnt_idx;
                        r_a      <= w_a[w_gnt_idx];
                        r_b      <= w_b[w_gnt_idx];
                        r_ctrl   <= w_ctrl[w_gnt_idx];
                        r_tag    <= w_tag[w_gnt_idx];
                        r_rr_ptr <= (w_gnt_idx == PTRW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                    end
                end
                EXEC: begin
                    r_rsp_result <= w_legal ? XLEN'(w_alu_result) : '0;
                    r_rsp_zero   <= w_legal ? w_alu_zero : 1'b1;
                    r_rsp_err    <= ~w_legal;
                    r_rsp_tag    <= r_tag;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule
